fx_param_ctrl: RTL and testbench

//  Runtime controller for the effects pipeline's gain and bypass. Debounces the two push keys,

---
 rtl/fx_ctrl_pkg.sv | 14 +
 rtl/fx_param_ctrl_if.sv | 22 ++
 rtl/key_debounce_repeat.sv | 101 ++++++++++
 rtl/fx_param_ctrl.sv | 95 +++++++++
 tb/tb_fx_param_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fx_ctrl_pkg.sv
// Shared types and constants for the effects parameter controller.
package fx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } key_fsm_e;

  localparam int KEY_DOWN  = 0;
  localparam int KEY_UP    = 1;
  localparam int LED_BAR_N = 9;

endpackage

// File: rtl/fx_param_ctrl_if.sv
// Board-side bundle of fx_param_ctrl: raw key/switch/tick inputs and committed outputs.
interface fx_param_ctrl_if #(
  parameter int gain_w = 10
);
  logic [1:0]        i_key_n;
  logic              i_sw_bypass;
  logic              i_sample_tick;
  logic [gain_w-1:0] o_par_gain;
  logic              o_bypass;
  logic              o_gain_changed;
  logic [9:0]        o_led;

  modport master (
    output i_key_n, i_sw_bypass, i_sample_tick,
    input  o_par_gain, o_bypass, o_gain_changed, o_led
  );

  modport slave (
    input  i_key_n, i_sw_bypass, i_sample_tick,
    output o_par_gain, o_bypass, o_gain_changed, o_led
  );
endinterface

// File: rtl/key_debounce_repeat.sv
// One push key: 2-FF synchroniser, stability debounce and hold/auto-repeat FSM.
// o_step is a 1-cycle pulse per press and per auto-repeat interval.
module key_debounce_repeat
  import fx_ctrl_pkg::*;
#(
  parameter int debounce_cyc      = 500_000,
  parameter int repeat_delay_cyc  = 25_000_000,
  parameter int repeat_period_cyc = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_step
);
  localparam int DW   = $clog2(debounce_cyc + 1);
  localparam int RMAX = (repeat_delay_cyc > repeat_period_cyc) ? repeat_delay_cyc : repeat_period_cyc;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(debounce_cyc - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(repeat_delay_cyc - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(repeat_period_cyc - 1);

  logic          sync1_q, sync2_q, stable_q;
  logic [DW-1:0] db_cnt_q;
  key_fsm_e      state_q, state_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          pressed;

  // Stable level flips after debounce_cyc consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= i_key_n;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        stable_q <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DW'(1);
      end
    end
  end

  assign pressed = ~stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q + RW'(1);
    case (state_q)
      IDLE: begin
        rep_cnt_d = '0;
        if (pressed) state_d = HOLD;
      end
      HOLD: begin
        if (!pressed) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == DELAY_LAST) begin
          state_d   = REPEAT;
          rep_cnt_d = '0;
        end
      end
      REPEAT: begin
        if (!pressed || rep_cnt_q == PERIOD_LAST) begin
          state_d   = pressed ? REPEAT : IDLE;
          rep_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        rep_cnt_d = '0;
      end
    endcase
  end

  // A release seen in the same cycle suppresses the step.
  always_comb begin
    o_step = 1'b0;
    case (state_q)
      IDLE:    o_step = pressed;
      HOLD:    o_step = pressed && (rep_cnt_q == DELAY_LAST);
      REPEAT:  o_step = pressed && (rep_cnt_q == PERIOD_LAST);
      default: o_step = 1'b0;
    endcase
  end
endmodule

// File: rtl/fx_param_ctrl.sv
// Gain/bypass runtime controller: saturating gain stepping from two keys,
// sample-aligned commit of gain and bypass, and LED bar decode.
module fx_param_ctrl
  import fx_ctrl_pkg::*;
#(
  parameter int gain_w            = 10,
  parameter int gain_default      = 256,
  parameter int gain_min          = 0,
  parameter int gain_max          = 1023,
  parameter int gain_step         = 16,
  parameter int debounce_cyc      = 500_000,
  parameter int repeat_delay_cyc  = 25_000_000,
  parameter int repeat_period_cyc = 5_000_000
) (
  input logic            clk,
  input logic            rst,
  fx_param_ctrl_if.slave bus
);
  localparam logic [gain_w:0]   STEP_X    = (gain_w + 1)'(gain_step);
  localparam logic [gain_w:0]   MIN_X     = (gain_w + 1)'(gain_min);
  localparam logic [gain_w:0]   MAX_X     = (gain_w + 1)'(gain_max);
  localparam logic [gain_w-1:0] DEFAULT_G = gain_w'(gain_default);
  localparam int                LVL_SH    = gain_w - 4;
  localparam logic [3:0]        BAR_N     = 4'(LED_BAR_N);

  logic [1:0]           step;
  logic                 byp_s1_q, byp_s2_q;
  logic [gain_w-1:0]    gain_nxt_q, gain_nxt_d, par_gain_q;
  logic                 bypass_q, changed_q;
  logic [gain_w:0]      gain_x, up_x, down_x;
  logic [3:0]           level_raw, level;
  logic [LED_BAR_N-1:0] led_bar;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      key_debounce_repeat #(
        .debounce_cyc     (debounce_cyc),
        .repeat_delay_cyc (repeat_delay_cyc),
        .repeat_period_cyc(repeat_period_cyc)
      ) u_key (
        .clk    (clk),
        .rst    (rst),
        .i_key_n(bus.i_key_n[gi]),
        .o_step (step[gi])
      );
    end
  endgenerate

  // One extra bit of headroom keeps both saturating directions free of wrap.
  always_comb begin
    gain_x = {1'b0, gain_nxt_q};
    up_x   = gain_x + STEP_X;
    if (up_x > MAX_X) up_x = MAX_X;
    down_x = (gain_x < MIN_X + STEP_X) ? MIN_X : gain_x - STEP_X;
    gain_nxt_d = gain_nxt_q;
    if (step[KEY_UP] && step[KEY_DOWN]) gain_nxt_d = DEFAULT_G;
    else if (step[KEY_UP])              gain_nxt_d = up_x[gain_w-1:0];
    else if (step[KEY_DOWN])            gain_nxt_d = down_x[gain_w-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_s1_q   <= 1'b0;
      byp_s2_q   <= 1'b0;
      gain_nxt_q <= DEFAULT_G;
      par_gain_q <= DEFAULT_G;
      bypass_q   <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      byp_s1_q   <= bus.i_sw_bypass;
      byp_s2_q   <= byp_s1_q;
      gain_nxt_q <= gain_nxt_d;
      changed_q  <= 1'b0;
      if (bus.i_sample_tick) begin
        par_gain_q <= gain_nxt_q;
        bypass_q   <= byp_s2_q;
        changed_q  <= (gain_nxt_q != par_gain_q);
      end
    end
  end

  assign level_raw = 4'(par_gain_q >> LVL_SH);
  assign level     = (level_raw > BAR_N) ? BAR_N : level_raw;

  generate
    for (genvar gi = 0; gi < LED_BAR_N; gi++) begin : g_led
      assign led_bar[gi] = (level > 4'(gi));
    end
  endgenerate

  assign bus.o_par_gain     = par_gain_q;
  assign bus.o_bypass       = bypass_q;
  assign bus.o_gain_changed = changed_q;
  assign bus.o_led          = {bypass_q, led_bar};
endmodule

// File: tb/tb_fx_param_ctrl.sv
// Scenario bench for fx_param_ctrl with short debounce/repeat timing and a tick every 10 cycles.
module tb_fx_param_ctrl;
  import fx_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fx_param_ctrl_if #(.gain_w(10)) ifc ();

  fx_param_ctrl #(
    .gain_w(10), .gain_default(256), .gain_min(0), .gain_max(1023), .gain_step(16),
    .debounce_cyc(4), .repeat_delay_cyc(20), .repeat_period_cyc(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int total = 0;
  int bad = 0;
  int model_gain = 256;
  int exp_q[$];
  int obs_q[$];
  int pulse_cnt = 0;
  int tick_phase = 0;

  initial begin
    ifc.i_sample_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ifc.i_sample_tick = (tick_phase == 9);
      tick_phase = (tick_phase + 1) % 10;
    end
  end

  // Each committed gain change is one transaction.
  initial begin
    forever begin
      @(negedge clk);
      if (ifc.o_gain_changed === 1'b1) begin
        obs_q.push_back(int'(ifc.o_par_gain));
        pulse_cnt++;
        $display("[%0t] commit gain=%0d bypass=%0d led=%b", $time, ifc.o_par_gain, ifc.o_bypass, ifc.o_led);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press a key pattern briefly (one step) and predict its effect.
  task automatic press(input int mask, input int hold);
    logic [1:0] m;
    int g;
    m = mask[1:0];
    ifc.i_key_n = ~m;
    cycles(hold);
    ifc.i_key_n = 2'b11;
    cycles(12);
    g = model_gain;
    if (mask == 3)      g = 256;
    else if (mask == 2) g = (g + 16 > 1023) ? 1023 : g + 16;
    else if (mask == 1) g = (g - 16 < 0) ? 0 : g - 16;
    if (g != model_gain) exp_q.push_back(g);
    model_gain = g;
  endtask

  task automatic align_tick();
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (ifc.i_sample_tick === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL align_tick: got no tick want tick within 20 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(3);
    total++; if (ifc.o_par_gain !== 10'd256) begin bad++; $display("FAIL reset_gain: got %0d want 256", ifc.o_par_gain); end
    total++; if (ifc.o_bypass !== 1'b0) begin bad++; $display("FAIL reset_bypass: got %0d want 0", ifc.o_bypass); end
    total++; if (ifc.o_gain_changed !== 1'b0) begin bad++; $display("FAIL reset_changed: got %0d want 0", ifc.o_gain_changed); end
    total++; if (ifc.o_led !== 10'b00_0000_1111) begin bad++; $display("FAIL reset_led: got %b want 0000001111", ifc.o_led); end
    rst = 1'b0;
    pulse_cnt = 0;
    cycles(50);
    total++; if (pulse_cnt != 0) begin bad++; $display("FAIL idle_pulses: got %0d want 0", pulse_cnt); end
    total++; if (ifc.o_par_gain !== 10'd256) begin bad++; $display("FAIL idle_gain: got %0d want 256", ifc.o_par_gain); end
  endtask

  task automatic test_bounce();
    obs_q.delete();
    for (int i = 0; i < 10; i++) begin
      ifc.i_key_n[1] = ~ifc.i_key_n[1];
      cycles(2);
    end
    ifc.i_key_n = 2'b11;
    cycles(30);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL bounce_pulses: got %0d want 0", obs_q.size()); end
    total++; if (ifc.o_par_gain !== 10'd256) begin bad++; $display("FAIL bounce_gain: got %0d want 256", ifc.o_par_gain); end
  endtask

  task automatic test_single();
    int e, o;
    obs_q.delete(); exp_q.delete();
    press(2, 10);
    cycles(20);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o != e) begin bad++; $display("FAIL single_value: got %0d want %0d", o, e); end
    end
    total++; if (ifc.o_par_gain !== 10'd272) begin bad++; $display("FAIL single_gain: got %0d want 272", ifc.o_par_gain); end
  endtask

  task automatic test_hold();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    model_gain = 256;
    obs_q.delete(); exp_q.delete();
    ifc.i_key_n[1] = 1'b0;
    cycles(57);
    ifc.i_key_n = 2'b11;
    cycles(40);
    model_gain = 256 + 6 * 16;
    total++; if (ifc.o_par_gain !== 10'(model_gain)) begin bad++; $display("FAIL hold_gain: got %0d want %0d", ifc.o_par_gain, model_gain); end
    total++;
    if (obs_q.size() == 0) begin bad++; $display("FAIL hold_pulses: got 0 want >0"); end
    else if (obs_q[$] != model_gain) begin bad++; $display("FAIL hold_last: got %0d want %0d", obs_q[$], model_gain); end
  endtask

  task automatic test_saturation();
    int e, o;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 43; i++) press(2, 10);
    cycles(15);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL sat_up_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o != e) begin bad++; $display("FAIL sat_up_value: got %0d want %0d", o, e); end
    end
    total++; if (ifc.o_par_gain !== 10'd1023) begin bad++; $display("FAIL sat_max: got %0d want 1023", ifc.o_par_gain); end
    total++; if (ifc.o_led !== 10'h1FF) begin bad++; $display("FAIL led_full: got %b want 0111111111", ifc.o_led); end
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 65; i++) press(1, 10);
    cycles(15);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL sat_dn_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o != e) begin bad++; $display("FAIL sat_dn_value: got %0d want %0d", o, e); end
    end
    total++; if (ifc.o_par_gain !== 10'd0) begin bad++; $display("FAIL sat_min: got %0d want 0", ifc.o_par_gain); end
    total++; if (ifc.o_led !== 10'h000) begin bad++; $display("FAIL led_empty: got %b want 0000000000", ifc.o_led); end
  endtask

  task automatic test_both_keys();
    int e, o;
    obs_q.delete(); exp_q.delete();
    press(3, 10);
    cycles(15);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL both_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o != e) begin bad++; $display("FAIL both_value: got %0d want %0d", o, e); end
    end
    total++; if (ifc.o_par_gain !== 10'd256) begin bad++; $display("FAIL both_gain: got %0d want 256", ifc.o_par_gain); end
  endtask

  task automatic test_bypass();
    align_tick();
    ifc.i_sw_bypass = 1'b1;
    cycles(9);
    total++; if (ifc.o_bypass !== 1'b0) begin bad++; $display("FAIL bypass_early: got %0d want 0", ifc.o_bypass); end
    total++; if (ifc.o_led[9] !== 1'b0) begin bad++; $display("FAIL led9_early: got %0d want 0", ifc.o_led[9]); end
    cycles(1);
    total++; if (ifc.o_bypass !== 1'b1) begin bad++; $display("FAIL bypass_commit: got %0d want 1", ifc.o_bypass); end
    total++; if (ifc.o_led !== 10'b10_0000_1111) begin bad++; $display("FAIL led_bypass: got %b want 1000001111", ifc.o_led); end
    $display("[%0t] bypass committed", $time);
  endtask

  task automatic test_rst_hold();
    align_tick();
    obs_q.delete();
    ifc.i_key_n[1] = 1'b0;
    cycles(8);
    rst = 1'b1;
    cycles(1);
    ifc.i_key_n = 2'b11;
    cycles(3);
    rst = 1'b0;
    total++; if (ifc.o_par_gain !== 10'd256) begin bad++; $display("FAIL rst_gain: got %0d want 256", ifc.o_par_gain); end
    total++; if (ifc.o_bypass !== 1'b0) begin bad++; $display("FAIL rst_bypass: got %0d want 0", ifc.o_bypass); end
    obs_q.delete();
    cycles(40);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rst_pending: got %0d commits want 0", obs_q.size()); end
    total++; if (ifc.o_par_gain !== 10'd256) begin bad++; $display("FAIL rst_after_gain: got %0d want 256", ifc.o_par_gain); end
  endtask

  initial begin
    ifc.i_key_n = 2'b11;
    ifc.i_sw_bypass = 1'b0;
    test_reset();
    test_bounce();
    test_single();
    test_hold();
    test_saturation();
    test_both_keys();
    test_bypass();
    test_rst_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
